// File: rtl/probe_capture_buffer_if.sv
// Readout stream of the probe capture buffer: valid/ready beats, oldest sample first.
interface probe_capture_buffer_if #(parameter int WIDTH = 8);
  logic             rd_valid;
  logic             rd_ready;
  logic [WIDTH-1:0] rd_data;
  logic             rd_last;

  modport master (output rd_valid, rd_data, rd_last, input rd_ready);
  modport slave  (input rd_valid, rd_data, rd_last, output rd_ready);
endinterface

// File: rtl/probe_capture_buffer.sv
// Logic-analyzer capture engine: circular sample buffer, pattern/external trigger, pre-trigger window.
// Optional: define PROBE_CAPTURE_EDGE_TRIG_EN for rising-edge trigger sensitivity.
module probe_capture_buffer #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 64,
  parameter int PRE_TRIG = DEPTH/2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             arm,
  input  logic             abort,
  input  logic [WIDTH-1:0] probe,
  input  logic [WIDTH-1:0] trig_mask,
  input  logic [WIDTH-1:0] trig_value,
  input  logic             trig_ext,
  output logic             armed,
  output logic             triggered,
  output logic             done,
  probe_capture_buffer_if.master rd
);
  localparam int ADDR_W   = $clog2(DEPTH);
  localparam int CNT_W    = ADDR_W + 1;
  localparam int POST_CNT = DEPTH - PRE_TRIG - 1;
  localparam logic [CNT_W-1:0]  PRE_LAST  = CNT_W'(PRE_TRIG == 0 ? 0 : PRE_TRIG - 1);
  localparam logic [CNT_W-1:0]  POST_LAST = CNT_W'(POST_CNT == 0 ? 0 : POST_CNT - 1);
  localparam logic [CNT_W-1:0]  BEATS     = CNT_W'(DEPTH);
  localparam logic [ADDR_W-1:0] PRE_OFS   = ADDR_W'(PRE_TRIG);

  typedef enum logic [2:0] {IDLE, PRE, WAIT_TRIG, POST, READOUT} state_t;

  state_t            state, state_nx;
  logic [WIDTH-1:0]  mem [DEPTH];
  logic [ADDR_W-1:0] wptr, rptr, trig_addr;
  logic [CNT_W-1:0]  cnt;
  logic              valid_q, last_q;
  logic [WIDTH-1:0]  data_q;
  logic              pat_match, hit, capturing, load, xfer;

  assign pat_match = (trig_mask != '0) && (((probe ^ trig_value) & trig_mask) == '0);

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
  logic prev_pat, prev_ext;
  // Pattern history restarts on WAIT_TRIG entry; trig_ext history runs continuously,
  // so an external trigger already high at arm time must drop and rise again.
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      prev_pat <= 1'b0;
      prev_ext <= 1'b0;
    end else begin
      prev_pat <= (state == WAIT_TRIG) ? pat_match : 1'b0;
      prev_ext <= trig_ext;
    end
  assign hit = (pat_match & ~prev_pat) | (trig_ext & ~prev_ext);
`else
  assign hit = pat_match | trig_ext;
`endif

  assign capturing = (state == PRE) || (state == WAIT_TRIG) || (state == POST);
  assign xfer      = valid_q && rd.rd_ready;
  assign load      = (state == READOUT) && (cnt != BEATS) && (!valid_q || rd.rd_ready);

  assign armed       = (state == PRE) || (state == WAIT_TRIG);
  assign triggered   = (state == POST) || (state == READOUT);
  assign done        = (state == READOUT);
  assign rd.rd_valid = valid_q;
  assign rd.rd_data  = data_q;
  assign rd.rd_last  = last_q;

  always_ff @(posedge clk or posedge rst)
    if (rst) state <= IDLE;
    else     state <= state_nx;

  always_comb begin
    state_nx = state;
    if (abort) state_nx = IDLE;
    else begin
      case (state)
        IDLE:      if (arm) state_nx = (PRE_TRIG == 0) ? WAIT_TRIG : PRE;
        PRE:       if (cnt == PRE_LAST) state_nx = WAIT_TRIG;
        WAIT_TRIG: if (hit) state_nx = (POST_CNT == 0) ? READOUT : POST;
        POST:      if (cnt == POST_LAST) state_nx = READOUT;
        READOUT:   if (xfer && last_q) state_nx = IDLE;
        default:   state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk)
    if (capturing) mem[wptr] <= probe;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr      <= '0;
      rptr      <= '0;
      trig_addr <= '0;
      cnt       <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      data_q    <= '0;
    end else if (abort) begin
      cnt     <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      case (state)
        IDLE: if (arm) begin
          wptr <= '0;
          cnt  <= '0;
        end
        PRE, POST: begin
          wptr <= wptr + ADDR_W'(1);
          cnt  <= (state_nx == state) ? cnt + CNT_W'(1) : '0;
        end
        WAIT_TRIG: begin
          wptr <= wptr + ADDR_W'(1);
          if (hit) begin
            trig_addr <= wptr;
            cnt       <= '0;
          end
        end
        READOUT: begin
          if (load) begin
            data_q  <= mem[rptr];
            rptr    <= rptr + ADDR_W'(1);
            cnt     <= cnt + CNT_W'(1);
            valid_q <= 1'b1;
            last_q  <= (cnt == BEATS - CNT_W'(1));
          end else if (xfer) begin
            valid_q <= 1'b0;
            last_q  <= 1'b0;
          end
        end
        default: ;
      endcase
      // Oldest sample of the window sits PRE_TRIG slots behind the trigger sample.
      if (state_nx == READOUT && state != READOUT)
        rptr <= ((state == WAIT_TRIG) ? wptr : trig_addr) - PRE_OFS;
    end
  end
endmodule

// File: tb/tb_probe_capture_buffer.sv
// Directed bench: three buffer instances (PRE_TRIG 4, 0, 15) with DEPTH=16, WIDTH=8.
`timescale 1ns/1ps
module tb_probe_capture_buffer;
  localparam int W = 8;
  localparam int D = 16;

  logic         clk = 1'b0;
  logic         rst;
  logic [2:0]   arm_v;
  logic         abort;
  logic [W-1:0] probe, mask, value;
  logic         ext, ready;
  logic         armed0, armed1, armed2, trig0, trig1, trig2, done0, done1, done2;
  int           sel;
  logic         s_valid, s_last, s_armed, s_trig, s_done;
  logic [W-1:0] s_data;
  int           n_chk = 0;
  int           n_fail = 0;

  probe_capture_buffer_if #(.WIDTH(W)) bus0 ();
  probe_capture_buffer_if #(.WIDTH(W)) bus1 ();
  probe_capture_buffer_if #(.WIDTH(W)) bus2 ();
  assign bus0.rd_ready = ready;
  assign bus1.rd_ready = ready;
  assign bus2.rd_ready = ready;

  probe_capture_buffer #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(4)) dut (
    .clk(clk), .rst(rst), .arm(arm_v[0]), .abort(abort), .probe(probe),
    .trig_mask(mask), .trig_value(value), .trig_ext(ext),
    .armed(armed0), .triggered(trig0), .done(done0), .rd(bus0.master));
  probe_capture_buffer #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(0)) dut_p0 (
    .clk(clk), .rst(rst), .arm(arm_v[1]), .abort(abort), .probe(probe),
    .trig_mask(mask), .trig_value(value), .trig_ext(ext),
    .armed(armed1), .triggered(trig1), .done(done1), .rd(bus1.master));
  probe_capture_buffer #(.WIDTH(W), .DEPTH(D), .PRE_TRIG(15)) dut_p15 (
    .clk(clk), .rst(rst), .arm(arm_v[2]), .abort(abort), .probe(probe),
    .trig_mask(mask), .trig_value(value), .trig_ext(ext),
    .armed(armed2), .triggered(trig2), .done(done2), .rd(bus2.master));

  always #5 clk = ~clk;

  always_comb begin
    case (sel)
      1: begin
        s_valid = bus1.rd_valid; s_data = bus1.rd_data; s_last = bus1.rd_last;
        s_armed = armed1; s_trig = trig1; s_done = done1;
      end
      2: begin
        s_valid = bus2.rd_valid; s_data = bus2.rd_data; s_last = bus2.rd_last;
        s_armed = armed2; s_trig = trig2; s_done = done2;
      end
      default: begin
        s_valid = bus0.rd_valid; s_data = bus0.rd_data; s_last = bus0.rd_last;
        s_armed = armed0; s_trig = trig0; s_done = done0;
      end
    endcase
  end

  // Arms instance `which`, drives probe = sample index, and checks the 16 readout beats
  // against start, start+1, ... (8-bit wrap). ext is high at sample ext_at and for samples < ext_hold.
  task automatic run_capture(input int which, input int ext_at, input int ext_hold,
                             input bit bp, input logic [7:0] start, input string tag);
    int smp, nb;
    bit fin, pv, pr, pl;
    logic [7:0] pd, exp;
    sel = which;
    @(negedge clk);
    arm_v = 3'b001 << which;
    probe = 8'hEE;
    ext   = (ext_hold > 0);
    @(negedge clk);
    arm_v = '0;
    smp = 0; nb = 0; fin = 0; pv = 0; pr = 0; pl = 0; pd = '0;
    for (int k = 0; k < 700 && !fin; k++) begin
      probe = smp[7:0];
      ext   = (smp == ext_at) || (smp < ext_hold);
      ready = !bp || (k % 4 == 0) || (k % 4 == 3);
      if (pv && !pr) begin
        n_chk++;
        if (s_valid !== 1'b1 || s_data !== pd || s_last !== pl) begin
          n_fail++;
          $display("FAIL %s stall_hold: valid=%b data=%h last=%b, required valid=1 data=%h last=%b",
                   tag, s_valid, s_data, s_last, pd, pl);
        end
      end
      if (s_valid && ready) begin
        exp = start + nb[7:0];
        n_chk++;
        if (s_data !== exp || s_last !== (nb == D-1)) begin
          n_fail++;
          $display("FAIL %s beat%0d: data=%h last=%b, required data=%h last=%b",
                   tag, nb, s_data, s_last, exp, (nb == D-1));
        end
        nb++;
        if (s_last) fin = 1;
      end
      pv = s_valid; pr = ready; pd = s_data; pl = s_last;
      @(negedge clk);
      smp++;
    end
    ready = 1'b1;
    ext   = 1'b0;
    n_chk++;
    if (!fin || nb != D) begin
      n_fail++;
      $display("FAIL %s beat_count: got %0d beats (last seen=%b), required %0d", tag, nb, fin, D);
    end
    n_chk++;
    if (s_valid !== 1'b0 || s_armed !== 1'b0 || s_trig !== 1'b0 || s_done !== 1'b0) begin
      n_fail++;
      $display("FAIL %s idle_after: valid=%b armed=%b trig=%b done=%b, required all 0",
               tag, s_valid, s_armed, s_trig, s_done);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_chk++;
    if ({armed0, trig0, done0, bus0.rd_valid, bus0.rd_last} !== 5'b0 || bus0.rd_data !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_dut: status=%b data=%h, required 00000 and 00",
               {armed0, trig0, done0, bus0.rd_valid, bus0.rd_last}, bus0.rd_data);
    end
    n_chk++;
    if ({armed1, trig1, done1, armed2, trig2, done2, bus1.rd_valid, bus2.rd_valid} !== 8'b0) begin
      n_fail++;
      $display("FAIL reset_variants: status=%b, required 0",
               {armed1, trig1, done1, armed2, trig2, done2, bus1.rd_valid, bus2.rd_valid});
    end
    rst = 1'b0;
    @(negedge clk);
    arm_v = 3'b001;
    @(negedge clk);
    arm_v = '0;
    n_chk++;
    if (armed0 !== 1'b1) begin
      n_fail++;
      $display("FAIL arm_status: armed=%b, required 1", armed0);
    end
    #2 rst = 1'b1;
    #1;
    n_chk++;
    if (armed0 !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_midop: armed=%b, required 0", armed0);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_pattern_trigger();
    mask = 8'hFF; value = 8'h0A;
    run_capture(0, -1, 0, 1'b0, 8'h06, "pattern");
  endtask

  task automatic test_pattern_wrap();
    mask = 8'hFF; value = 8'h02;
    run_capture(0, -1, 0, 1'b0, 8'hFE, "pattern_wrap");
  endtask

  task automatic test_ext_trigger();
    mask = 8'h00;
    run_capture(0, 20, 0, 1'b0, 8'd16, "ext");
  endtask

  task automatic test_back_pressure();
    mask = 8'hFF; value = 8'h0A;
    run_capture(0, -1, 0, 1'b1, 8'h06, "backpressure");
  endtask

  task automatic test_abort();
    mask = 8'h00; sel = 0;
    @(negedge clk);
    arm_v = 3'b001;
    @(negedge clk);
    arm_v = '0;
    for (int s = 0; s < 10; s++) begin
      probe = s[7:0];
      ext   = (s == 6);
      @(negedge clk);
    end
    ext = 1'b0;
    n_chk++;
    if (trig0 !== 1'b1 || done0 !== 1'b0) begin
      n_fail++;
      $display("FAIL abort_pre_post: triggered=%b done=%b, required 1 0", trig0, done0);
    end
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    n_chk++;
    if ({armed0, trig0, done0, bus0.rd_valid} !== 4'b0) begin
      n_fail++;
      $display("FAIL abort_outputs: status=%b, required 0000", {armed0, trig0, done0, bus0.rd_valid});
    end
    run_capture(0, 20, 0, 1'b0, 8'd16, "rearm_after_abort");
  endtask

  task automatic test_pre_variants();
    mask = 8'h00;
    run_capture(1, 5, 0, 1'b0, 8'd5, "pre0");
    run_capture(2, 20, 0, 1'b0, 8'd5, "pre15");
  endtask

`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
  task automatic test_edge_trigger();
    mask = 8'h00;
    run_capture(0, 12, 10, 1'b0, 8'd8, "edge_ext");
  endtask
`endif

  initial begin
    rst = 1'b1; arm_v = '0; abort = 1'b0; probe = '0; mask = '0; value = '0;
    ext = 1'b0; ready = 1'b1; sel = 0;
    test_reset();
    test_pattern_trigger();
    test_pattern_wrap();
    test_ext_trigger();
    test_back_pressure();
    test_abort();
    test_pre_variants();
`ifdef PROBE_CAPTURE_EDGE_TRIG_EN
    test_edge_trigger();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/probe_capture_buffer.md
Name: probe_capture_buffer

Overview:
- Parametrised logic-analyzer capture engine for fabric debug probes.
- Records a WIDTH-bit probe bus into a circular buffer of DEPTH samples.
- Trigger sources: masked pattern match or external trigger; keeps a programmable pre-trigger window.
- Captured window is streamed out over a valid/ready port to the debug/JTAG side.

Parameters:
WIDTH, 8, probe and sample width in bits
DEPTH, 64, samples per capture; power of two, >= 4
PRE_TRIG, DEPTH/2, samples kept before the trigger sample; range 0..DEPTH-1

Ports:
clk  input  1  sole clock; probe sampled on rising edge
rst  input  1  asynchronous active-high reset
arm  input  1  single-cycle start request; honoured only in IDLE
abort  input  1  synchronous return to IDLE from any state; overrides arm
probe  input  WIDTH  sampled probe bus
trig_mask  input  WIDTH  pattern mask; all-zero disables pattern trigger
trig_value  input  WIDTH  pattern compare value
trig_ext  input  1  external trigger; level, sampled each cycle
armed  output  1  high in PRE and WAIT_TRIG
triggered  output  1  high in POST and READOUT
done  output  1  high in READOUT
rd_valid  output  1  readout beat available
rd_ready  input  1  consumer accepts beat
rd_data  output  WIDTH  sample, oldest first
rd_last  output  1  high with the final (DEPTH-th) beat

Behaviour:
- Reset: state IDLE; armed, triggered, done, rd_valid, rd_last = 0; rd_data = 0; pointers and counters = 0. Buffer contents are not reset.
- States: IDLE, PRE, WAIT_TRIG, POST, READOUT.
- IDLE: arm=1 -> PRE, or -> WAIT_TRIG when PRE_TRIG=0. wptr cleared.
- Sample numbering: sample 0 is probe on the first edge after the arm edge.
- Writes: in PRE, WAIT_TRIG and POST, mem[wptr] <= probe every cycle; wptr increments modulo DEPTH.
- PRE: counts PRE_TRIG writes, then -> WAIT_TRIG. Trigger conditions are ignored, so the pre-trigger window is always filled with fresh samples.
- WAIT_TRIG: hit = trig_ext | (trig_mask != 0 && ((probe ^ trig_value) & trig_mask) == 0).
  - The hit sample is written; trig_addr <= wptr; -> POST with post count DEPTH-PRE_TRIG-1.
  - If the post count is 0, -> READOUT directly.
  - wptr wraps indefinitely while waiting.
- POST: writes post-count samples, then -> READOUT.
- READOUT:
  - rptr starts at (trig_addr - PRE_TRIG) mod DEPTH; ADDR_W-bit modular arithmetic.
  - Registered memory read.
  - First rd_valid rises no later than 2 cycles after READOUT entry.
  - Beat transfers when rd_valid & rd_ready.
  - rd_data and rd_last hold stable while rd_valid=1 and rd_ready=0.
  - rd_valid may stay high back-to-back: one beat per cycle when rd_ready is held high.
  - After the DEPTH-th transfer (rd_last=1), next cycle rd_valid=0 -> IDLE.
- Ignored inputs: arm outside IDLE; arm and trigger in the same cycle as the arm edge (triggering starts from WAIT_TRIG only).
- abort: -> IDLE next cycle. All status outputs and rd_valid are 0 that cycle; an in-flight beat is dropped.
- rst mid-operation: immediate return to reset values.

Optional Feature:
- Macro: PROBE_CAPTURE_EDGE_TRIG_EN.
- Defined: pattern hit fires only on a rising match, i.e. match this cycle and no match on the previous sample (previous-match register is cleared on entering WAIT_TRIG). trig_ext becomes rising-edge sensitive the same way.
- Undefined: level-sensitive as described above; no extra registers.

Test Plan:
- WIDTH=8, DEPTH=16, PRE_TRIG=4; probe = sample index; mask=FF, value=0x0A -> 16 beats 0x06..0x15, rd_last on 0x15, then IDLE.
- Same config, value=0x02 (falls inside PRE) -> hit ignored; match at sample 0x102 (8-bit wrap) -> beats 0xFE,0xFF,0x00..0x0D.
- mask=00, trig_ext pulsed at sample 20 -> beats 16..31. With the edge macro defined and trig_ext held high from arm -> no trigger until it falls and rises again.
- Readout with rd_ready toggling 1-0-0-1 -> no beat lost or duplicated; rd_data stable while stalled; exactly 16 transfers.
- abort asserted in POST -> next cycle all outputs 0; a new arm restarts a full capture correctly.
- PRE_TRIG=0 and PRE_TRIG=15 variants -> trigger sample is beat 0 and beat 15 respectively.
